uart_tx: RTL and testbench

UART transmitter that serialises one byte per request into an 8-N-1 frame (optionally 8-E-1) on the UART transmit pin. It pairs with the existing UART receiver in the serial-port design and shares its baud-rate parameters. It runs on the system clock and exposes a single-cycle request handshake, so a loopback or command-reply path can drive it directly from the receiver's done/data outputs.

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises one byte per accepted request into an
// 8-N-1 frame (8-E-1 when UART_TX_PARITY_EN is defined) on uart_txd.
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   uart_tx_en   transmit request, accepted only while not busy
//   uart_tx_data byte to send, latched on acceptance
//   uart_tx_busy high while a frame is on the line
//   uart_tx_done one-cycle pulse after the stop bit completes
//   uart_txd     registered serial output, idle high
module uart_tx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_busy,
  output logic       uart_tx_done,
  output logic       uart_txd
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BaudLast     = 16'(BAUD_CNT_MAX - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        txd_q, txd_d;
  logic        baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign baud_wrap = (baud_cnt_q == BaudLast);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q == StIdle) begin
      baud_cnt_d = 16'd0;
    end else begin
      baud_cnt_d = baud_wrap ? 16'd0 : baud_cnt_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        // In IDLE busy_q is always low, so any request here is accepted.
        if (uart_tx_en) begin
          shift_d   = uart_tx_data;
          bit_cnt_d = 3'd0;
          state_d   = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^uart_tx_data;
`endif
        end
      end
      StStart: begin
        if (baud_wrap) state_d = StData;
      end
      StData: begin
        if (baud_wrap) begin
          // LSB first: the next data bit is always at shift_q[0].
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_wrap) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_wrap) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);

    // Line level is a function of the next state so it appears registered
    // in the same cycle the state takes effect.
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign uart_tx_busy = busy_q;
  assign uart_tx_done = done_q;
  assign uart_txd     = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at default baud parameters.
// The driver pushes each byte expected on the line into a queue; a monitor
// decodes frames from uart_txd at bit midpoints, checks framing and timing,
// and pops/compares the data byte.
module tb_uart_tx;

  localparam int B = 50000000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int NB = NBITS * B;

  logic       clk;
  logic       rst_n;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       uart_tx_done;
  logic       uart_txd;

  int checks;
  int failures;
  int done_cnt;
  logic [7:0] exp_q[$];

  uart_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_done (uart_tx_done),
    .uart_txd     (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Done pulse counter.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && uart_tx_done === 1'b1) done_cnt++;
  end

  // Monitor: detect start on a 1->0 transition, sample each bit midpoint.
  initial begin : monitor
    logic       prev;
    logic       active;
    logic       busy_bad;
    logic [NBITS-1:0] bits;
    logic [7:0] got;
    logic [7:0] exp;
    int t;
    prev   = 1'b0;
    active = 1'b0;
    busy_bad = 1'b0;
    bits   = '0;
    t      = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        active = 1'b0;
        prev   = 1'b0;
        continue;
      end
      if (!active && prev === 1'b1 && uart_txd === 1'b0) begin
        active   = 1'b1;
        t        = 0;
        busy_bad = 1'b0;
        bits     = '0;
      end
      if (active) begin
        if (t < NB) begin
          if (uart_tx_busy !== 1'b1 || uart_tx_done !== 1'b0) busy_bad = 1'b1;
          if (t % B == B / 2) bits[t / B] = uart_txd;
        end else begin
          chk("start_bit", 32'(bits[0]), 32'd0);
          chk("stop_bit", 32'(bits[NBITS-1]), 32'd1);
          chk("busy_held_whole_frame", 32'(busy_bad), 32'd0);
          chk("frame_end_done_busy_txd",
              32'({uart_tx_done, uart_tx_busy, uart_txd}), 32'b101);
          got = bits[8:1];
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got %0h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            chk("data_byte", 32'(got), 32'(exp));
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", 32'(bits[9]), 32'(^exp));
`endif
          end
          active = 1'b0;
        end
        t++;
      end
      prev = uart_txd;
    end
  end

  task automatic send(input logic [7:0] b, input bit expect_frame);
    @(posedge clk);
    #1;
    uart_tx_en   = 1'b1;
    uart_tx_data = b;
    if (expect_frame) exp_q.push_back(b);
    @(posedge clk);
    #1;
    uart_tx_en = 1'b0;
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < NB + 2 * B; i++) begin
      @(negedge clk);
      if (uart_tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic idle_bad;
    checks       = 0;
    failures     = 0;
    done_cnt     = 0;
    rst_n        = 1'b0;
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'hAA;

    // Reset with a request pending: reset wins.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_outputs", 32'({uart_txd, uart_tx_busy, uart_tx_done}), 32'b100);
    end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    uart_tx_en = 1'b0;
    idle_bad   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if ({uart_txd, uart_tx_busy, uart_tx_done} !== 3'b100) idle_bad = 1'b1;
    end
    chk("idle_after_reset", 32'(idle_bad), 32'd0);

    // Basic frame.
    send(8'h55, 1'b1);
    wait_done("frame_55");

    // Parity-relevant byte (three ones -> parity 1 when enabled).
    repeat (10) @(posedge clk);
    send(8'h07, 1'b1);
    wait_done("frame_07");

    // Busy rejection with data churn during the frame.
    repeat (10) @(posedge clk);
    send(8'hA5, 1'b1);
    repeat (1000) @(posedge clk);
    send(8'h3C, 1'b0);
    uart_tx_data = 8'hFF;
    repeat (500) @(posedge clk);
    #1;
    uart_tx_data = 8'h00;
    wait_done("frame_a5");
    repeat (5) @(negedge clk);
    chk("no_frame_after_reject", 32'(uart_tx_busy), 32'd0);

    // Back-to-back: request in the done cycle.
    repeat (10) @(posedge clk);
    send(8'h12, 1'b1);
    wait_done("frame_12");
    uart_tx_en   = 1'b1;
    uart_tx_data = 8'h34;
    exp_q.push_back(8'h34);
    @(posedge clk);
    #1;
    uart_tx_en = 1'b0;
    @(negedge clk);
    chk("b2b_start_next_cycle", 32'({uart_txd, uart_tx_busy}), 32'b01);
    wait_done("frame_34");

    // Mid-frame reset during data bit 3 of 0xF0.
    repeat (10) @(posedge clk);
    send(8'hF0, 1'b0);
    repeat (4 * B + B / 2 - 1) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_bit3_low", 32'({uart_txd, uart_tx_busy}), 32'b01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midframe_reset_outputs", 32'({uart_txd, uart_tx_busy, uart_tx_done}), 32'b100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (NB + 10) @(posedge clk);
    chk("no_done_after_abort", 32'(done_cnt), 32'd5);

    // Recovery frame.
    send(8'h81, 1'b1);
    wait_done("frame_81");

    repeat (20) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pulse_count", 32'(done_cnt), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
